// File: rtl/host_bootdata_streamer.sv
// Host-side boot-data streamer: packs loader bytes into 32-bit little-endian
// words and hands each one to the memory side over a 4-phase req/ack handshake.
// Finishes with done after WORD_COUNT words, or with error on an ack timeout.
module host_bootdata_streamer #(
  parameter int WORD_COUNT  = 8192,
  parameter int CNT_W       = 14,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       byte_data,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [31:0]      host_bootdata,
  output logic             host_bootdata_req,
  input  logic             host_bootdata_ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_sent
);

  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WORD_COUNT_C  = CNT_W'(WORD_COUNT);
  localparam logic [TMO_W-1:0] ACK_TIMEOUT_C = TMO_W'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_REQ      = 3'd2,
    ST_WAIT_LOW = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERROR    = 3'd5
  } state_t;

  state_t             state_r;
  logic [1:0]         lane_r;
  logic [TMO_W-1:0]   tmo_r;
  logic [TMO_W-1:0]   tmo_inc_s;
  logic [31:0]        word_r;
  logic               byte_ready_r;
  logic               req_r;
  logic               busy_r;
  logic               done_r;
  logic               error_r;
  logic [CNT_W-1:0]   words_sent_r;

  // Next value of the ack-phase timeout counter; it never exceeds ACK_TIMEOUT
  // because the FSM leaves REQ/WAIT_LOW as soon as the limit is reached.
  assign tmo_inc_s = tmo_r + TMO_W'(1'b1);

  // Single FSM: byte packing, handshake sequencing, timeout and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      lane_r       <= 2'd0;
      tmo_r        <= '0;
      word_r       <= 32'd0;
      byte_ready_r <= 1'b0;
      req_r        <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      words_sent_r <= '0;
    end else begin
      case (state_r)
        // Idle and both terminal states wait for a start pulse.
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_r      <= ST_FILL;
            lane_r       <= 2'd0;
            tmo_r        <= '0;
            byte_ready_r <= 1'b1;
            busy_r       <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
            words_sent_r <= '0;
          end
        end

        // Collect four bytes; gaps in byte_valid simply hold the lane.
        ST_FILL: begin
          if (byte_valid) begin
            word_r[{lane_r, 3'b000} +: 8] <= byte_data;
            if (lane_r == 2'd3) begin
              state_r      <= ST_REQ;
              lane_r       <= 2'd0;
              tmo_r        <= '0;
              byte_ready_r <= 1'b0;
              req_r        <= 1'b1;
            end else begin
              lane_r <= lane_r + 2'd1;
            end
          end
        end

        // Present the word; an ack already high on entry counts as valid.
        ST_REQ: begin
          if (host_bootdata_ack) begin
            state_r <= ST_WAIT_LOW;
            tmo_r   <= '0;
            req_r   <= 1'b0;
            if (words_sent_r != WORD_COUNT_C) begin
              words_sent_r <= words_sent_r + CNT_W'(1'b1);
            end
          end else if (tmo_inc_s == ACK_TIMEOUT_C) begin
            state_r <= ST_ERROR;
            tmo_r   <= '0;
            req_r   <= 1'b0;
            busy_r  <= 1'b0;
            error_r <= 1'b1;
          end else begin
            tmo_r <= tmo_inc_s;
          end
        end

        // Wait for ack to fall so one ack pulse is never counted twice.
        ST_WAIT_LOW: begin
          if (!host_bootdata_ack) begin
            tmo_r <= '0;
            if (words_sent_r == WORD_COUNT_C) begin
              state_r <= ST_DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r      <= ST_FILL;
              lane_r       <= 2'd0;
              byte_ready_r <= 1'b1;
            end
          end else if (tmo_inc_s == ACK_TIMEOUT_C) begin
            state_r <= ST_ERROR;
            tmo_r   <= '0;
            busy_r  <= 1'b0;
            error_r <= 1'b1;
          end else begin
            tmo_r <= tmo_inc_s;
          end
        end

        default: begin
          state_r      <= ST_IDLE;
          lane_r       <= 2'd0;
          tmo_r        <= '0;
          byte_ready_r <= 1'b0;
          req_r        <= 1'b0;
          busy_r       <= 1'b0;
          done_r       <= 1'b0;
          error_r      <= 1'b0;
        end
      endcase
    end
  end

  assign byte_ready        = byte_ready_r;
  assign host_bootdata     = word_r;
  assign host_bootdata_req = req_r;
  assign busy              = busy_r;
  assign done              = done_r;
  assign error             = error_r;
  assign words_sent        = words_sent_r;

endmodule

// File: tb/tb_host_bootdata_streamer.sv
// Self-checking bench for host_bootdata_streamer (WORD_COUNT=2, ACK_TIMEOUT=16):
// directed handshake/timeout/reset scenarios plus randomized images scored
// against a transaction-level model of the byte-to-word packing.
module tb_host_bootdata_streamer;

  localparam int WC = 2;
  localparam int CW = 2;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic [31:0]   host_bootdata;
  logic          host_bootdata_req;
  logic          host_bootdata_ack;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] words_sent;

  int total = 0;
  int bad   = 0;

  host_bootdata_streamer #(.WORD_COUNT(WC), .CNT_W(CW), .ACK_TIMEOUT(TO)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .byte_data         (byte_data),
    .byte_valid        (byte_valid),
    .byte_ready        (byte_ready),
    .host_bootdata     (host_bootdata),
    .host_bootdata_req (host_bootdata_req),
    .host_bootdata_ack (host_bootdata_ack),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .words_sent        (words_sent)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  // Count one comparison and report it if observed differs from expected.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference packing: first byte is least significant.
  function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
    return 32'(b0) + (32'(b1) << 8) + (32'(b2) << 16) + (32'(b3) << 24);
  endfunction

  // Present one byte for a single cycle while the streamer is expected ready.
  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    check("fill_ready", 32'(byte_ready), 32'd1);
    step();
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // One randomized image: random byte gaps, junk while not ready, random ack timing.
  task automatic run_image();
    logic [7:0]  b[4];
    logic [31:0] exp_word;
    int          sent;
    int          idx;
    int          cyc;
    logic        v;
    sent = 0;
    pulse_start();
    check("rnd_start_busy", 32'(busy), 32'd1);
    check("rnd_start_ws", 32'(words_sent), 32'd0);
    for (int w = 0; w < WC; w++) begin
      for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
      exp_word = pack(b[0], b[1], b[2], b[3]);
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 200) begin
        v          = 1'($urandom_range(0, 1));
        byte_valid = v;
        byte_data  = v ? b[idx] : 8'($urandom);
        check("rnd_fill_ready", 32'(byte_ready), 32'd1);
        step();
        cyc++;
        if (v) idx++;
      end
      check("rnd_fill_bound", 32'(idx), 32'd4);
      byte_valid = 1'b0;
      check("rnd_req_rise", 32'(host_bootdata_req), 32'd1);
      check("rnd_word", host_bootdata, exp_word);
      repeat ($urandom_range(0, 5)) begin
        byte_valid = 1'($urandom_range(0, 1));
        byte_data  = 8'($urandom);
        step();
        check("rnd_req_hold", 32'(host_bootdata_req), 32'd1);
        check("rnd_word_hold", host_bootdata, exp_word);
        check("rnd_req_notready", 32'(byte_ready), 32'd0);
      end
      host_bootdata_ack = 1'b1;
      step();
      sent++;
      check("rnd_req_fall", 32'(host_bootdata_req), 32'd0);
      check("rnd_ws", 32'(words_sent), 32'(sent));
      check("rnd_word_wl", host_bootdata, exp_word);
      repeat ($urandom_range(0, 2)) begin
        byte_valid = 1'($urandom_range(0, 1));
        byte_data  = 8'($urandom);
        step();
        check("rnd_wl_notready", 32'(byte_ready), 32'd0);
        check("rnd_wl_req", 32'(host_bootdata_req), 32'd0);
      end
      host_bootdata_ack = 1'b0;
      byte_valid        = 1'b0;
      step();
      if (sent == WC) begin
        check("rnd_done", 32'(done), 32'd1);
        check("rnd_done_busy", 32'(busy), 32'd0);
        check("rnd_done_ready", 32'(byte_ready), 32'd0);
      end else begin
        check("rnd_next_ready", 32'(byte_ready), 32'd1);
        check("rnd_not_done", 32'(done), 32'd0);
      end
    end
    byte_valid = 1'b1;
    byte_data  = 8'($urandom);
    repeat (3) begin
      step();
      check("rnd_extra_ready", 32'(byte_ready), 32'd0);
      check("rnd_extra_ws", 32'(words_sent), 32'(WC));
    end
    byte_valid = 1'b0;
  endtask

  // Hard stop in case the sequence below ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus sequence.
  initial begin
    reset             = 1'b1;
    start             = 1'b0;
    byte_valid        = 1'b0;
    byte_data         = 8'd0;
    host_bootdata_ack = 1'b0;
    step();
    step();
    check("rst_req", 32'(host_bootdata_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_ready", 32'(byte_ready), 32'd0);
    check("rst_ws", 32'(words_sent), 32'd0);
    check("rst_data", host_bootdata, 32'd0);
    reset = 1'b0;
    step();
    check("idle_ready", 32'(byte_ready), 32'd0);

    // Basic packing and handshake latency.
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("t1_no_req_early", 32'(host_bootdata_req), 32'd0);
    send_byte(8'h44);
    check("t1_req", 32'(host_bootdata_req), 32'd1);
    check("t1_word", host_bootdata, 32'h4433_2211);
    check("t1_ready_drop", 32'(byte_ready), 32'd0);
    repeat (3) begin
      step();
      check("t1_req_hold", 32'(host_bootdata_req), 32'd1);
      check("t1_word_hold", host_bootdata, 32'h4433_2211);
    end
    host_bootdata_ack = 1'b1;
    step();
    check("t1_req_fall", 32'(host_bootdata_req), 32'd0);
    check("t1_ws", 32'(words_sent), 32'd1);
    step();
    check("t1_wait_ready", 32'(byte_ready), 32'd0);
    host_bootdata_ack = 1'b0;
    step();
    check("t1_ready_back", 32'(byte_ready), 32'd1);

    // Gapped byte_valid keeps packing intact; second word completes the image.
    foreach (byte_data[i]) begin end
    begin
      logic [7:0] seq[4];
      seq[0] = 8'hEF; seq[1] = 8'hBE; seq[2] = 8'hAD; seq[3] = 8'hDE;
      for (int i = 0; i < 4; i++) begin
        byte_valid = 1'b0;
        byte_data  = 8'h5A;
        step();
        send_byte(seq[i]);
      end
    end
    check("t5_req", 32'(host_bootdata_req), 32'd1);
    check("t5_word", host_bootdata, 32'hDEAD_BEEF);
    host_bootdata_ack = 1'b1;
    step();
    check("t5_ws", 32'(words_sent), 32'd2);
    host_bootdata_ack = 1'b0;
    step();
    check("t2_done", 32'(done), 32'd1);
    check("t2_busy", 32'(busy), 32'd0);
    check("t2_ws", 32'(words_sent), 32'd2);
    byte_valid = 1'b1;
    byte_data  = 8'h99;
    repeat (3) begin
      step();
      check("t2_extra_ready", 32'(byte_ready), 32'd0);
      check("t2_extra_req", 32'(host_bootdata_req), 32'd0);
    end
    byte_valid = 1'b0;

    // Ack held high: each ack pulse counts exactly once.
    pulse_start();
    check("t4_done_clr", 32'(done), 32'd0);
    check("t4_ws_clr", 32'(words_sent), 32'd0);
    host_bootdata_ack = 1'b1;
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
    check("t4_req", 32'(host_bootdata_req), 32'd1);
    check("t4_word", host_bootdata, 32'hA4A3_A2A1);
    step();
    check("t4_ws1", 32'(words_sent), 32'd1);
    repeat (5) begin
      step();
      check("t4_ws_held", 32'(words_sent), 32'd1);
      check("t4_ready_held", 32'(byte_ready), 32'd0);
    end
    host_bootdata_ack = 1'b0;
    step();
    check("t4_ready", 32'(byte_ready), 32'd1);
    host_bootdata_ack = 1'b1;
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3); send_byte(8'hB4);
    check("t4_word2", host_bootdata, 32'hB4B3_B2B1);
    step();
    check("t4_ws2", 32'(words_sent), 32'd2);
    repeat (3) begin
      step();
      check("t4_ws2_held", 32'(words_sent), 32'd2);
      check("t4_not_done", 32'(done), 32'd0);
    end
    host_bootdata_ack = 1'b0;
    step();
    check("t4_done", 32'(done), 32'd1);

    // Ack never arrives: error exactly ACK_TIMEOUT cycles after req rises.
    pulse_start();
    send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3); send_byte(8'hC4);
    check("t3_req", 32'(host_bootdata_req), 32'd1);
    for (int k = 1; k < TO; k++) begin
      step();
      check("t3_no_err_yet", 32'(error), 32'd0);
      check("t3_req_hold", 32'(host_bootdata_req), 32'd1);
    end
    step();
    check("t3_error", 32'(error), 32'd1);
    check("t3_req_low", 32'(host_bootdata_req), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_done", 32'(done), 32'd0);
    pulse_start();
    check("t3_err_clr", 32'(error), 32'd0);
    check("t3_rebusy", 32'(busy), 32'd1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check("t3_resume_word", host_bootdata, 32'h0403_0201);
    host_bootdata_ack = 1'b1;
    step();
    check("t3_resume_ws", 32'(words_sent), 32'd1);
    host_bootdata_ack = 1'b0;
    step();

    // Reset while a request is outstanding.
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    check("t6_req", 32'(host_bootdata_req), 32'd1);
    reset = 1'b1;
    step();
    check("t6_req", 32'(host_bootdata_req), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ws", 32'(words_sent), 32'd0);
    check("t6_data", host_bootdata, 32'd0);
    reset = 1'b0;
    step();

    // Randomized images against the packing model.
    for (int n = 0; n < 12; n++) run_image();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
